gates_checker: RTL and testbench

GATES_CHECKER -- requirements
Module: gates_checker

---
 rtl/gates_checker.sv | 120 ++++++++++++
 tb/tb_gates_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gates_checker.sv
// Walks {a,b} through 00,01,10,11 and checks the OR/AND/NOT responses on c1..c3.
// Latency: done rises 4*SETTLE cycles after the start edge; start is ignored while busy.
module gates_checker #(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       c1,
   input  logic       c2,
   input  logic       c3,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_vec
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state, state_nxt;
   logic [3:0] settle_cnt, settle_nxt;
   logic [1:0] idx, idx_nxt;
   logic       a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
   logic [2:0] err_nxt;
   logic [3:0] fail_nxt;
   logic       cmp_edge;
   logic       last_vec;
   logic       vec_bad;
   logic       run_req;

   assign cmp_edge = (state == RUN) && (settle_cnt == 4'(SETTLE - 1));
   assign last_vec = (idx == 2'd3);
   assign run_req  = (state != RUN) && start;
   // Case inequality so an X/Z response is treated as a mismatch.
   assign vec_bad  = (c1 !== (a | b)) || (c2 !== (a & b)) || (c3 !== ~a);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         idx        <= '0;
         a          <= 1'b0;
         b          <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_vec   <= '0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
         idx        <= idx_nxt;
         a          <= a_nxt;
         b          <= b_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         pass       <= pass_nxt;
         err_count  <= err_nxt;
         fail_vec   <= fail_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (cmp_edge && last_vec) state_nxt = DONE;
         DONE:    if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      settle_nxt = settle_cnt;
      idx_nxt    = idx;
      a_nxt      = a;
      b_nxt      = b;
      busy_nxt   = busy;
      done_nxt   = done;
      pass_nxt   = pass;
      err_nxt    = err_count;
      fail_nxt   = fail_vec;
      if (run_req) begin
         settle_nxt = '0;
         idx_nxt    = '0;
         a_nxt      = 1'b0;
         b_nxt      = 1'b0;
         busy_nxt   = 1'b1;
         done_nxt   = 1'b0;
         pass_nxt   = 1'b0;
         err_nxt    = '0;
         fail_nxt   = '0;
      end else if (state == RUN) begin
         if (cmp_edge) begin
            settle_nxt = '0;
            if (vec_bad) begin
               fail_nxt[idx] = 1'b1;
               if (err_count != 3'd4) err_nxt = err_count + 3'd1;
            end
            if (last_vec) begin
               idx_nxt  = '0;
               a_nxt    = 1'b0;
               b_nxt    = 1'b0;
               busy_nxt = 1'b0;
               done_nxt = 1'b1;
               pass_nxt = (err_nxt == 3'd0);
            end else begin
               idx_nxt        = idx + 2'd1;
               {a_nxt, b_nxt} = idx_nxt;
            end
         end else begin
            settle_nxt = settle_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_gates_checker.sv
// Bench for gates_checker: directed runs with known faulty gate models, then
// randomized start/reset/fault traffic checked every cycle against a run-time model.
module tb_gates_checker;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       a, b, c1, c2, c3, busy, done, pass;
   logic [2:0] err_count;
   logic [3:0] fail_vec;

   int          fault_sel = 0;
   logic [11:0] rand_mask = '0;
   int          vectors = 0;
   int          miscompares = 0;
   logic        cmp_en = 1'b0;

   // Second instance: SETTLE=1, correct gates, start held high.
   logic       rst1 = 1'b0;
   logic       start1 = 1'b0;
   logic       a1, b1, c1_1, c2_1, c3_1, busy1, done1, pass1;
   logic [2:0] err1;
   logic [3:0] fail1;

   always #5 clk = ~clk;

   function automatic logic nand2(logic x, logic y);
      return ~(x & y);
   endfunction

   // Gate-under-test models: 0 NAND-built correct, 1 c3 stuck 0, 2 c1 built as AND,
   // 3 per-vector random flips taken from msk.
   function automatic logic [2:0] gate_resp(int mode, logic [11:0] msk, logic x, logic y);
      logic [2:0] r;
      int k;
      r = {nand2(~x, ~y), ~nand2(x, y), nand2(x, x)};
      k = int'(x) * 2 + int'(y);
      case (mode)
         1: r[0] = 1'b0;
         2: r[2] = x & y;
         3: r = r ^ msk[3*k +: 3];
         default: ;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] expected_mask(int mode, logic [11:0] msk);
      logic [3:0] m;
      logic x, y;
      m = '0;
      for (int v = 0; v < 4; v++) begin
         x = v[1];
         y = v[0];
         m[v] = (gate_resp(mode, msk, x, y) != {x | y, x & y, ~x});
      end
      return m;
   endfunction

   assign {c1, c2, c3}       = gate_resp(fault_sel, rand_mask, a, b);
   assign {c1_1, c2_1, c3_1} = gate_resp(0, 12'd0, a1, b1);

   gates_checker #(.SETTLE(S)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .c1(c1), .c2(c2), .c3(c3), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_vec(fail_vec)
   );

   gates_checker #(.SETTLE(1)) dut1 (
      .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
      .c1(c1_1), .c2(c2_1), .c3(c3_1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_vec(fail1)
   );

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Run model: time since the start edge decides which vectors have been judged.
   logic       m_run = 1'b0;
   logic       m_done = 1'b0;
   int         m_t = 0;
   logic [3:0] m_exp = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run  = 1'b0;
         m_done = 1'b0;
         m_t    = 0;
         m_exp  = '0;
      end else if (!m_run && start) begin
         m_run  = 1'b1;
         m_done = 1'b0;
         m_t    = 0;
         m_exp  = expected_mask(fault_sel, rand_mask);
      end else if (m_run) begin
         m_t++;
         if (m_t == 4 * S) begin
            m_run  = 1'b0;
            m_done = 1'b1;
         end
      end
   end

   function automatic logic [11:0] model_out();
      int judged, cur;
      logic [3:0] ef;
      logic [1:0] ab;
      judged = m_run ? m_t / S : 4;
      cur    = m_run ? m_t / S : 0;
      ab     = cur[1:0];
      ef     = '0;
      for (int i = 0; i < 4; i++) if (i < judged) ef[i] = m_exp[i];
      return {ab, m_run, m_done, m_done && (ef == 4'd0), 3'($countones(ef)), ef};
   endfunction

   always @(negedge clk) begin
      if (cmp_en)
         check("cycle", {20'd0, a, b, busy, done, pass, err_count, fail_vec}, {20'd0, model_out()});
   end

   int e1 = 0;
   int last1 = 0;
   int nr1 = 0;
   logic prev1 = 1'b0;

   always @(posedge clk) if (!rst1 && start1) e1++;

   always @(negedge clk) begin
      if (!rst1 && start1) begin
         if (done1 && !prev1) begin
            if (nr1 == 0) check("s1_first_done", e1, 5);
            else          check("s1_done_period", e1 - last1, 5);
            check("s1_pass", {pass1, err1, fail1}, {1'b1, 3'd0, 4'd0});
            last1 = e1;
            nr1++;
         end
         prev1 = done1;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Start a run, optionally re-pulse start or assert reset at a given cycle,
   // and return the cycle count at which done was seen (40 if never).
   task automatic do_run(input int restart_at, input int rst_at, output int cyc);
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 0;
      while (cyc < 40) begin
         cyc++;
         start = (cyc == restart_at);
         if (cyc == rst_at) rst = 1'b1;
         step();
         start = 1'b0;
         rst   = 1'b0;
         if (done) break;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500000");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      #1 rst = 1'b1;
      rst1   = 1'b1;
      cmp_en = 1'b1;
      repeat (3) step();
      check("reset_state", {a, b, busy, done, pass, err_count, fail_vec}, 12'd0);
      rst    = 1'b0;
      rst1   = 1'b0;
      start1 = 1'b1;
      step();

      fault_sel = 0;
      do_run(0, 0, cyc);
      check("latency_good", cyc, 8);
      check("result_good", {pass, err_count, fail_vec}, {1'b1, 3'd0, 4'b0000});

      fault_sel = 1;
      do_run(0, 0, cyc);
      check("latency_c3_stuck", cyc, 8);
      check("result_c3_stuck", {pass, err_count, fail_vec}, {1'b0, 3'd2, 4'b0011});

      fault_sel = 2;
      do_run(0, 0, cyc);
      check("result_c1_and", {pass, err_count, fail_vec}, {1'b0, 3'd2, 4'b0110});

      fault_sel = 0;
      do_run(3, 0, cyc);
      check("latency_restart_ignored", cyc, 8);
      check("result_restart_ignored", {pass, err_count, fail_vec}, {1'b1, 3'd0, 4'b0000});

      fault_sel = 1;
      start = 1'b1;
      step();
      start = 1'b0;
      check("rerun_clears", {busy, done, pass, err_count, fail_vec}, {1'b1, 1'b0, 1'b0, 3'd0, 4'd0});
      repeat (10) step();
      check("rerun_result", {done, err_count, fail_vec}, {1'b1, 3'd2, 4'b0011});

      fault_sel = 0;
      do_run(0, 5, cyc);
      check("reset_midrun_no_done", {cyc[7:0], done, busy}, {8'd40, 1'b0, 1'b0});
      do_run(0, 0, cyc);
      check("latency_after_reset", cyc, 8);

      for (int i = 0; i < 400; i++) begin
         if (!m_run && $urandom_range(0, 3) == 0) begin
            fault_sel = $urandom_range(0, 3);
            rand_mask = 12'($urandom);
         end
         start = ($urandom_range(0, 4) == 0);
         rst   = ($urandom_range(0, 60) == 0);
         step();
      end
      rst   = 1'b0;
      start = 1'b0;
      repeat (2) step();

      check("s1_runs_seen", int'(nr1 >= 20), 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
